// File: rtl/kernel_neighbor_fetch.sv
// kernel_neighbor_fetch: fetches a center sample and its two lower diagonal
// neighbours (bottom-left, bottom-right) from a frame memory. Neighbours that
// fall outside the frame are never read; they are returned as zero and flagged
// in out_mask. Latency from accept to out_valid is fixed regardless of mask.
module kernel_neighbor_fetch #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int FRAME_WIDTH = 64,
  parameter int FRAME_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_width,
  input  logic [ADDR_W-1:0]     in_depth,
  output logic                  mem_rd_en,
  output logic [2*ADDR_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_c,
  output logic [DATA_W-1:0]     out_bl,
  output logic [DATA_W-1:0]     out_br,
  output logic [2:0]            out_mask
);

  localparam int AW2 = 2 * ADDR_W;

  // Frame limits carried one bit wider than a coordinate so that w+1 / d+1
  // can be compared without wrapping back into the frame.
  localparam logic [ADDR_W:0] FW  = (ADDR_W+1)'(FRAME_WIDTH);
  localparam logic [ADDR_W:0] FD  = (ADDR_W+1)'(FRAME_DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE, ISSUE_C, ISSUE_BL, ISSUE_BR, CAPT_BR, OUT
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_alive;
  logic [ADDR_W-1:0]   r_col;
  logic [ADDR_W-1:0]   r_row;
  logic [DATA_W-1:0]   r_outC;
  logic [DATA_W-1:0]   r_outBl;
  logic [DATA_W-1:0]   r_outBr;
  logic [2:0]          r_outMask;

  logic [ADDR_W:0]     w_colExt;
  logic [ADDR_W:0]     w_rowExt;
  logic [ADDR_W:0]     w_colP1;
  logic [ADDR_W:0]     w_rowP1;
  logic                w_inC;
  logic                w_inBl;
  logic                w_inBr;
  logic [AW2-1:0]      w_rowBase;
  logic [AW2-1:0]      w_rowBaseNext;
  logic [AW2-1:0]      w_addrC;
  logic [AW2-1:0]      w_addrBl;
  logic [AW2-1:0]      w_addrBr;
  logic                w_accept;

  // Bounds tests on the registered center; every neighbour needs the center
  // itself in-frame, and BL additionally needs a column to its left.
  assign w_colExt = {1'b0, r_col};
  assign w_rowExt = {1'b0, r_row};
  assign w_colP1  = w_colExt + ONE;
  assign w_rowP1  = w_rowExt + ONE;
  assign w_inC    = (w_colExt < FW) && (w_rowExt < FD);
  assign w_inBl   = w_inC && (r_col != '0) && (w_rowP1 < FD);
  assign w_inBr   = w_inC && (w_colP1 < FW) && (w_rowP1 < FD);

  // Linear addresses; only meaningful when the matching in-frame flag is set.
  assign w_rowBase     = AW2'(r_row) * AW2'(FRAME_WIDTH);
  assign w_rowBaseNext = w_rowBase + AW2'(FRAME_WIDTH);
  assign w_addrC       = w_rowBase + AW2'(r_col);
  assign w_addrBl      = w_rowBaseNext + AW2'(r_col) - AW2'(1);
  assign w_addrBr      = w_rowBaseNext + AW2'(r_col) + AW2'(1);

  assign w_accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // Latches the center coordinate on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= in_width;
      r_row <= in_depth;
    end
  end

  // Next-state: fixed read/capture sequence, then wait for the consumer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = ISSUE_C;
      ISSUE_C:  w_nextState = ISSUE_BL;
      ISSUE_BL: w_nextState = ISSUE_BR;
      ISSUE_BR: w_nextState = CAPT_BR;
      CAPT_BR:  w_nextState = OUT;
      OUT:      if (out_ready) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the current state.
  always_comb begin
    in_ready    = r_alive && (r_state == IDLE);
    out_valid   = (r_state == OUT);
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (r_state)
      ISSUE_C: if (w_inC) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_addrC;
      end
      ISSUE_BL: if (w_inBl) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_addrBl;
      end
      ISSUE_BR: if (w_inBr) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_addrBr;
      end
      default: ;
    endcase
  end

  // Captures each read one cycle after it was issued; skipped reads yield 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outC    <= '0;
      r_outBl   <= '0;
      r_outBr   <= '0;
      r_outMask <= '0;
    end else begin
      case (r_state)
        ISSUE_BL: r_outC  <= w_inC  ? mem_rd_data : '0;
        ISSUE_BR: r_outBl <= w_inBl ? mem_rd_data : '0;
        CAPT_BR: begin
          r_outBr   <= w_inBr ? mem_rd_data : '0;
          r_outMask <= {w_inC, w_inBl, w_inBr};
        end
        default: ;
      endcase
    end
  end

  assign out_c    = r_outC;
  assign out_bl   = r_outBl;
  assign out_br   = r_outBr;
  assign out_mask = r_outMask;

endmodule

// File: tb/tb_kernel_neighbor_fetch.sv
// tb_kernel_neighbor_fetch: drives directed and random center coordinates into
// kernel_neighbor_fetch over a 64x64 frame whose memory returns its own address.
module tb_kernel_neighbor_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int FW     = 64;
  localparam int FD     = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_width;
  logic [ADDR_W-1:0]   in_depth;
  logic                mem_rd_en;
  logic [2*ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_c;
  logic [DATA_W-1:0]   out_bl;
  logic [DATA_W-1:0]   out_br;
  logic [2:0]          out_mask;

  typedef struct packed {
    logic [2:0]  mask;
    logic [15:0] addrC;
    logic [15:0] addrBl;
    logic [15:0] addrBr;
  } expT;

  int   compared   = 0;
  int   mismatched = 0;
  int   cycleCount = 0;
  int   resultsDone = 0;
  bit   modelBusy  = 0;
  bit   modelAlive = 0;
  int   modelCyc   = 0;
  bit   randomReady = 0;
  expT  cur;
  int   acceptLog[$];

  kernel_neighbor_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WIDTH(FW), .FRAME_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_width(in_width), .in_depth(in_depth),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_bl(out_bl), .out_br(out_br), .out_mask(out_mask)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Frame memory: a read returns its address one cycle later; otherwise the
  // bus carries junk so a skipped read cannot accidentally look like zero.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem_rd_addr : 16'($urandom);
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference: neighbour coordinates and in-frame flags from plain integers.
  function automatic expT refModel(input int w, input int d);
    expT e;
    bit inC, inBl, inBr;
    inC  = (w < FW) && (d < FD);
    inBl = inC && (w - 1 >= 0) && (w - 1 < FW) && (d + 1 < FD);
    inBr = inC && (w + 1 >= 0) && (w + 1 < FW) && (d + 1 < FD);
    e.mask   = {inC, inBl, inBr};
    e.addrC  = inC  ? 16'(d * FW + w)           : 16'd0;
    e.addrBl = inBl ? 16'((d + 1) * FW + w - 1) : 16'd0;
    e.addrBr = inBr ? 16'((d + 1) * FW + w + 1) : 16'd0;
    return e;
  endfunction

  // Compare process: checks every output against the model on each falling
  // edge, then advances the model to what the next rising edge will do.
  always @(negedge clk) begin
    bit          expEn;
    logic [15:0] expAddr;
    bit          expValid;
    cycleCount++;
    if (!rst_n) begin
      checkOutput("rst in_ready", in_ready, 0);
      checkOutput("rst mem_rd_en", mem_rd_en, 0);
      checkOutput("rst mem_rd_addr", mem_rd_addr, 0);
      checkOutput("rst out_valid", out_valid, 0);
      checkOutput("rst out_c", out_c, 0);
      checkOutput("rst out_bl", out_bl, 0);
      checkOutput("rst out_br", out_br, 0);
      checkOutput("rst out_mask", out_mask, 0);
      modelBusy  = 0;
      modelAlive = 0;
    end else begin
      checkOutput("in_ready", in_ready, modelAlive && !modelBusy);
      expEn   = 0;
      expAddr = 16'd0;
      if (modelBusy) begin
        case (modelCyc)
          0: begin expEn = cur.mask[2]; expAddr = cur.addrC;  end
          1: begin expEn = cur.mask[1]; expAddr = cur.addrBl; end
          2: begin expEn = cur.mask[0]; expAddr = cur.addrBr; end
          default: ;
        endcase
      end
      checkOutput("mem_rd_en", mem_rd_en, expEn);
      checkOutput("mem_rd_addr", mem_rd_addr, expAddr);
      expValid = modelBusy && (modelCyc >= 4);
      checkOutput("out_valid", out_valid, expValid);
      if (expValid) begin
        checkOutput("out_c", out_c, cur.addrC);
        checkOutput("out_bl", out_bl, cur.addrBl);
        checkOutput("out_br", out_br, cur.addrBr);
        checkOutput("out_mask", out_mask, cur.mask);
      end
      if (!modelBusy) begin
        if (modelAlive && in_valid) begin
          cur       = refModel(int'(in_width), int'(in_depth));
          modelBusy = 1;
          modelCyc  = 0;
          acceptLog.push_back(cycleCount);
        end
      end else if (modelCyc >= 4 && out_ready) begin
        modelBusy = 0;
        resultsDone++;
      end else begin
        modelCyc++;
      end
      modelAlive = 1;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (randomReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input int w, input int d);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_width = ADDR_W'(w);
    in_depth = ADDR_W'(d);
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (in_ready) accepted = 1;
      stepCycle();
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic waitResult(output int steps);
    steps = 0;
    while (!out_valid && steps < 20) begin
      stepCycle();
      steps++;
    end
    if (!out_valid) checkOutput("result timeout", 0, 1);
  endtask

  task automatic checkResult(input string tag, input int c, input int bl, input int br, input int m);
    checkOutput({tag, " out_c"}, out_c, c);
    checkOutput({tag, " out_bl"}, out_bl, bl);
    checkOutput({tag, " out_br"}, out_br, br);
    checkOutput({tag, " out_mask"}, out_mask, m);
  endtask

  initial begin
    expT e;
    int  steps;
    int  n0;
    int  done0;
    int  w;
    int  d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_width  = '0;
    in_depth  = '0;
    out_ready = 1'b1;

    // Literal expectations that pin the reference model itself.
    e = refModel(10, 5);
    checkOutput("model (10,5) mask", e.mask, 3'b111);
    checkOutput("model (10,5) C", e.addrC, 330);
    checkOutput("model (10,5) BL", e.addrBl, 393);
    checkOutput("model (10,5) BR", e.addrBr, 395);
    e = refModel(0, 5);
    checkOutput("model (0,5) mask", e.mask, 3'b101);
    e = refModel(63, 63);
    checkOutput("model (63,63) mask", e.mask, 3'b100);

    repeat (3) stepCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready before first edge", in_ready, 0);
    stepCycle();
    checkOutput("in_ready after release", in_ready, 1);

    $display("[TB] directed centers");
    applyStimulus(10, 5);
    waitResult(steps);
    checkOutput("(10,5) latency", steps, 4);
    checkResult("(10,5)", 330, 393, 395, 3'b111);
    stepCycle();

    applyStimulus(0, 5);
    waitResult(steps);
    checkResult("(0,5)", 320, 0, 385, 3'b101);
    stepCycle();

    applyStimulus(63, 63);
    waitResult(steps);
    checkOutput("(63,63) latency", steps, 4);
    checkResult("(63,63)", 4095, 0, 0, 3'b100);
    stepCycle();

    applyStimulus(200, 3);
    waitResult(steps);
    checkOutput("(200,3) latency", steps, 4);
    checkResult("(200,3)", 0, 0, 0, 3'b000);
    stepCycle();

    $display("[TB] output stall");
    out_ready = 1'b0;
    applyStimulus(10, 5);
    waitResult(steps);
    for (int i = 0; i < 3; i++) begin
      checkResult("stall", 330, 393, 395, 3'b111);
      checkOutput("stall in_ready", in_ready, 0);
      checkOutput("stall mem_rd_en", mem_rd_en, 0);
      checkOutput("stall out_valid", out_valid, 1);
      stepCycle();
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("post-handshake in_ready", in_ready, 1);
    checkOutput("post-handshake out_valid", out_valid, 0);
    checkResult("retained", 330, 393, 395, 3'b111);

    $display("[TB] reset during read sequence");
    applyStimulus(20, 10);
    stepCycle();
    checkOutput("pre-reset mem_rd_en", mem_rd_en, 1);
    checkOutput("pre-reset mem_rd_addr", mem_rd_addr, 723);
    rst_n = 1'b0;
    #1;
    checkOutput("reset mem_rd_en", mem_rd_en, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(1, 1);
    waitResult(steps);
    checkResult("(1,1)", 65, 128, 130, 3'b111);
    stepCycle();

    $display("[TB] back-to-back");
    n0    = acceptLog.size();
    done0 = resultsDone;
    applyStimulus(5, 5);
    applyStimulus(0, 0);
    applyStimulus(63, 0);
    applyStimulus(30, 62);
    waitResult(steps);
    stepCycle();
    stepCycle();
    checkOutput("b2b accept count", acceptLog.size() - n0, 4);
    for (int i = n0 + 1; i < acceptLog.size(); i++)
      checkOutput("b2b spacing", acceptLog[i] - acceptLog[i-1], 6);
    checkOutput("b2b results", resultsDone - done0, 4);

    $display("[TB] random traffic");
    randomReady = 1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0:       begin w = 63; d = $urandom_range(0, 63); end
        1:       begin w = 0;  d = $urandom_range(0, 63); end
        2:       begin w = $urandom_range(0, 63); d = 63; end
        3:       begin w = $urandom_range(64, 255); d = $urandom_range(0, 255); end
        default: begin w = $urandom_range(0, 69); d = $urandom_range(0, 69); end
      endcase
      repeat ($urandom_range(0, 2)) stepCycle();
      applyStimulus(w, d);
    end
    randomReady = 0;
    out_ready   = 1'b1;
    for (int i = 0; i < 20 && modelBusy; i++) stepCycle();
    stepCycle();
    checkOutput("drain idle", modelBusy, 0);
    checkOutput("drain in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit in case a wait escapes its bound.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
